// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and
// ID-stage operand forward selects.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF   = 2'd0;
  localparam logic [1:0] FWD_EALU = 2'd1;
  localparam logic [1:0] FWD_MALU = 2'd2;
  localparam logic [1:0] FWD_MMEM = 2'd3;

endpackage

// File: rtl/pipe_fwd_unit.sv
// Forward select for one ID-stage source operand; EX result beats MEM,
// and register 0 is never forwarded.
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic       ewreg,
  input  logic       em2reg,
  input  logic [4:0] ern,
  input  logic       mwreg,
  input  logic       mm2reg,
  input  logic [4:0] mrn,
  output logic [1:0] fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (ewreg && !em2reg && (ern != 5'd0) && (ern == src))
      fwd = FWD_EALU;
    else if (mwreg && (mrn != 5'd0) && (mrn == src))
      fwd = mm2reg ? FWD_MMEM : FWD_MALU;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/forward/flush controller for the 5-stage pipeline, with a
// data-memory wait FSM (timeout to sticky error) and a saturating stall counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       drs,
  input  logic [4:0]       drt,
  input  logic             duse_rs,
  input  logic             duse_rt,
  input  logic             dbranch,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [4:0]       ern,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic [4:0]       mrn,
  input  logic             mmemop,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             de_en,
  output logic             de_bubble,
  output logic             em_en,
  output logic             mw_bubble,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  state_t        state;
  logic [WW-1:0] wcnt;
  logic [1:0]    fwd_rs, fwd_rt;
  logic          lu, ms;

  pipe_fwd_unit u_fwd_rs (
    .src(drs), .ewreg(ewreg), .em2reg(em2reg), .ern(ern),
    .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn), .fwd(fwd_rs)
  );

  pipe_fwd_unit u_fwd_rt (
    .src(drt), .ewreg(ewreg), .em2reg(em2reg), .ern(ern),
    .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn), .fwd(fwd_rt)
  );

  assign lu = ewreg && em2reg && (ern != 5'd0) &&
              ((duse_rs && (ern == drs)) || (duse_rt && (ern == drt)));
  assign ms = ((state == RUN) && mmemop && !dmem_ready) ||
              ((state == MEM_WAIT) && !dmem_ready);

  // Release from MEM_WAIT is combinational on dmem_ready, so no extra cycle.
  always_comb begin
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    de_en     = 1'b1;
    em_en     = 1'b1;
    fd_flush  = dbranch;
    de_bubble = 1'b0;
    mw_bubble = 1'b0;
    fwda      = fwd_rs;
    fwdb      = fwd_rt;
    if (reset || (state == ERR) || ms) begin
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      de_en     = 1'b0;
      em_en     = 1'b0;
      fd_flush  = 1'b0;
      mw_bubble = 1'b1;
    end else if (lu) begin
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      fd_flush  = 1'b0;
      de_bubble = 1'b1;
    end
    if (reset) begin
      fwda = FWD_RF;
      fwdb = FWD_RF;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RUN;
      wcnt      <= '0;
      stall_cnt <= '0;
      mem_err   <= 1'b0;
    end else begin
      if (!pc_en && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      case (state)
        RUN: begin
          if (mmemop && !dmem_ready) begin
            state <= MEM_WAIT;
            wcnt  <= '0;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state <= RUN;
          end else if (wcnt == WAIT_LAST) begin
            state   <= ERR;
            mem_err <= 1'b1;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        default: state <= ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed plus randomized bench for pipe_hazard_ctrl against a cycle-level
// behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic reset;
  logic [4:0] drs, drt, ern, mrn;
  logic duse_rs, duse_rt, dbranch, ewreg, em2reg, mwreg, mm2reg, mmemop, dmem_ready;
  logic pc_en, fd_en, fd_flush, de_en, de_bubble, em_en, mw_bubble, mem_err;
  logic [1:0] fwda, fwdb;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // model: waiting flag, number of wait cycles already spent, error flag, stall count
  bit m_wait, m_err;
  int m_waits, m_stalls;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .drs(drs), .drt(drt), .duse_rs(duse_rs),
    .duse_rt(duse_rt), .dbranch(dbranch), .ewreg(ewreg), .em2reg(em2reg),
    .ern(ern), .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn), .mmemop(mmemop),
    .dmem_ready(dmem_ready), .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush),
    .de_en(de_en), .de_bubble(de_bubble), .em_en(em_en), .mw_bubble(mw_bubble),
    .fwda(fwda), .fwdb(fwdb), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] mfwd(input logic [4:0] r);
    if (ewreg && !em2reg && ern != 0 && ern == r) return 2'd1;
    if (mwreg && mrn != 0 && mrn == r) return mm2reg ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  // Check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic cycle();
    logic [6:0] ectl;
    logic [1:0] fa, fb;
    bit lu, ms;
    @(negedge clock);
    lu = ewreg && em2reg && ern != 0 &&
         ((duse_rs && ern == drs) || (duse_rt && ern == drt));
    ms = m_wait ? !dmem_ready : (mmemop && !dmem_ready);
    fa = mfwd(drs);
    fb = mfwd(drt);
    if (reset) begin
      ectl = 7'b0000001; fa = 0; fb = 0;
    end else if (m_err || ms) ectl = 7'b0000001;
    else if (lu)              ectl = 7'b0001110;
    else                      ectl = {2'b11, dbranch, 4'b1010};
    chk("ctl", {pc_en, fd_en, fd_flush, de_en, de_bubble, em_en, mw_bubble}, ectl);
    chk("fwda", fwda, fa);
    chk("fwdb", fwdb, fb);
    if (!reset) begin
      chk("mem_err", mem_err, m_err);
      chk("stall_cnt", stall_cnt, m_stalls);
    end
    @(posedge clock);
    if (reset) begin
      m_wait = 0; m_err = 0; m_waits = 0; m_stalls = 0;
    end else begin
      if (!ectl[6] && m_stalls < CNT_MAX) m_stalls++;
      if (!m_err) begin
        if (m_wait) begin
          if (dmem_ready) m_wait = 0;
          else if (m_waits + 1 == TIMEOUT) begin m_wait = 0; m_err = 1; end
          else m_waits++;
        end else if (mmemop && !dmem_ready) begin
          m_wait = 1; m_waits = 0;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    drs = 0; drt = 0; duse_rs = 0; duse_rt = 0; dbranch = 0;
    ewreg = 0; em2reg = 0; ern = 0; mwreg = 0; mm2reg = 0; mrn = 0;
    mmemop = 0; dmem_ready = 1;
  endtask

  initial begin
    idle();
    reset = 1;
    cycle(); cycle();
    reset = 0;
    chk("rst_err", mem_err, 0);
    chk("rst_cnt", stall_cnt, 0);

    // forwarding priority
    ern = 5; ewreg = 1; em2reg = 0; drs = 5; duse_rs = 1; mrn = 5; mwreg = 1;
    cycle(); chk("fwd_ex", fwda, 2'd1);
    ewreg = 0; cycle(); chk("fwd_malu", fwda, 2'd2);
    mm2reg = 1; cycle(); chk("fwd_mmem", fwda, 2'd3);
    drs = 0; ern = 0; cycle(); chk("fwd_r0", fwda, 2'd0);

    // load-use defers a taken branch
    idle();
    ewreg = 1; em2reg = 1; ern = 3; drt = 3; duse_rt = 1; dbranch = 1;
    cycle();
    chk("lu_pc", pc_en, 0); chk("lu_bub", de_bubble, 1); chk("lu_flush", fd_flush, 0);
    ern = 4; cycle(); chk("br_flush", fd_flush, 1);

    // three-cycle memory wait
    idle(); reset = 1; cycle(); reset = 0;
    mmemop = 1; dmem_ready = 0;
    repeat (3) begin cycle(); chk("mw_pc", pc_en, 0); chk("mw_bub", mw_bubble, 1); end
    dmem_ready = 1; cycle(); chk("mw_rel", pc_en, 1);
    mmemop = 0; cycle(); chk("mw_cnt", stall_cnt, 3);

    // single-cycle access
    mmemop = 1; dmem_ready = 1; cycle();
    chk("sc_pc", pc_en, 1); chk("sc_cnt", stall_cnt, 3);

    // timeout into sticky error
    dmem_ready = 0;
    repeat (TIMEOUT + 1) cycle();
    chk("to_err", mem_err, 1);
    mmemop = 0; dmem_ready = 1; cycle();
    chk("to_frz", pc_en, 0); chk("to_mwb", mw_bubble, 1);
    reset = 1; cycle(); reset = 0;
    chk("to_clr", mem_err, 0); chk("to_cnt", stall_cnt, 0);
    cycle(); chk("to_run", pc_en, 1);

    // saturation
    ewreg = 1; em2reg = 1; ern = 7; drs = 7; duse_rs = 1;
    repeat (20) cycle();
    chk("sat", stall_cnt, CNT_MAX);

    // randomized traffic
    idle(); reset = 1; cycle(); reset = 0;
    repeat (600) begin
      reset      = ($urandom_range(0, 59) == 0);
      drs        = 5'($urandom_range(0, 3));
      drt        = 5'($urandom_range(0, 3));
      ern        = 5'($urandom_range(0, 3));
      mrn        = 5'($urandom_range(0, 3));
      duse_rs    = 1'($urandom);
      duse_rt    = 1'($urandom);
      dbranch    = 1'($urandom);
      ewreg      = 1'($urandom);
      em2reg     = 1'($urandom);
      mwreg      = 1'($urandom);
      mm2reg     = 1'($urandom);
      mmemop     = ($urandom_range(0, 2) == 0);
      dmem_ready = ($urandom_range(0, 9) < 6);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
